unified_memory_arbiter: RTL
===========================

# unified_memory_arbiter

- Shares one single-ported unified memory between the CPU's instruction-fetch port and data port, so a core built on program_counter/register_file/alu can run against a single memory.
- Sits between the core's memory ports and the memory model.
- Provides round-robin arbitration, a per-transaction request/acknowledge handshake toward each requester, a ready handshake toward memory, a watchdog timeout and a contention counter.

## Interface
Parameters:
- COUNT_WIDTH, 16, width of conflict_count.
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without mem_ready before abort; must be ≥1.

Ports:
- clock  in  1  single clock; everything on rising edge.
- reset  in  1  asynchronous, active-low.
- imem_req  in  1  instruction read request; held with address until imem_ack.
- imem_address  in  [31:2]  word address.
- imem_ack  out  1  one-cycle completion pulse.
- imem_rdata  out  32  fetched word; valid while imem_ack is high, held after.
- dmem_req  in  1  data request; held with all inputs until dmem_ack.
- dmem_address  in  [31:2]  word address.
- dmem_write_enable  in  1  1 = store, 0 = load.
- dmem_write_data  in  32  store data.
- dmem_ack  out  1  one-cycle completion pulse.
- dmem_rdata  out  32  load data; valid while dmem_ack is high; unchanged by stores.
- mem_req  out  1  memory access strobe.
- mem_address  out  [31:2]  latched address.
- mem_write_enable  out  1  store strobe; only ever high together with mem_req.
- mem_write_data  out  32  latched store data.
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  32  read data; valid when mem_ready is high.
- conflict_count  out  COUNT_WIDTH  saturating count of cycles in which both requesters were pending in IDLE.
- timeout_error  out  1  sticky; set on any watchdog abort.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request pending: stay in IDLE.
- IDLE, exactly one request pending: grant it.
- IDLE, both requests pending: grant the requester that was not last_grant, then increment conflict_count, saturating at all-ones.
- On grant, latch address, write enable and write data. Set last_grant to the winner. Go to BUSY.
- BUSY: mem_req=1. mem_address, mem_write_enable and mem_write_data are driven from the latched values; mem_write_enable is 1 only for a data store.
- BUSY, mem_ready=1: capture mem_rdata into the granted requester's rdata register. Stores do not capture. Go to RESP.
- BUSY, mem_ready=0: increment wait_count.
- BUSY, wait_count reaches TIMEOUT_CYCLES−1 with mem_ready still low: abort. Load rdata = 32'h0, set timeout_error, go to RESP.
- RESP: mem_req=0. Pulse the granted ack for exactly this cycle. Clear wait_count. Return to IDLE.
- Requester rule: deassert req in the cycle after seeing ack, or keep it high to issue a back-to-back request. Requests are evaluated again in IDLE.
- The ungranted requester keeps waiting: its req stays high, no ack.
- Reset (async, any state):
  - state=IDLE, last_grant=data, so instruction wins the first tie.
  - All acks, mem_req and mem_write_enable are 0.
  - rdata registers 0, conflict_count 0, timeout_error 0, wait_count 0.
  - Any in-flight memory access is abandoned.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Request seen in IDLE at edge N → mem_req high in cycle N+1.
- mem_ready sampled high at edge M → ack and rdata valid in cycle M+1.
- Minimum request-to-ack latency: 3 cycles (IDLE, BUSY, RESP).
- Back-to-back service: one transaction per 3 cycles.
- mem_address, mem_write_enable and mem_write_data are stable for the whole BUSY period.
- Abort timing: ack arrives TIMEOUT_CYCLES+1 cycles after the first BUSY cycle.
- mem_ready in IDLE or RESP is ignored.

## Structure
- Shared package `memory_arbiter_pkg` holds:
  - state encoding localparams (IDLE/BUSY/RESP);
  - grant encoding (GRANT_INSTRUCTION, GRANT_DATA);
  - abort read value 32'h0.
- One sub-module, `round_robin_picker_2`: combinational winner select from the two reqs plus last_grant, and a tie flag.
- The FSM, latches, counters and watchdog stay in the top module.

## Test plan
- Single instruction fetch: imem_req with address 30'h10; memory ready on the first BUSY cycle with rdata 32'h2402_0005 → mem_address 30'h10 for one cycle; imem_ack one pulse 3 cycles after request; imem_rdata 32'h2402_0005.
- Simultaneous requests from reset, both held: instruction (0x4) and data load (0x100) → grant order I, D, I, D; conflict_count increments once per tie evaluation.
- Data store: address 30'h40, data 32'hCAFE_F00D, memory with 2 wait states → mem_write_enable=1 and data stable for 3 BUSY cycles; dmem_ack once; dmem_rdata unchanged.
- Watchdog: TIMEOUT_CYCLES=4, mem_ready never asserted → abort after 4 BUSY cycles; imem_ack with rdata 0; timeout_error stays 1 through later good transactions.
- Reset asserted in BUSY → mem_req=0 immediately (asynchronous); no ack; after release, first tie goes to instruction.
- conflict_count with COUNT_WIDTH=2 under sustained contention → saturates at 3.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, grant identities
// and the read value returned when the watchdog aborts an access.
package memory_arbiter_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_BUSY = 2'd1;
    localparam logic [1:0] STATE_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        BUSY = STATE_BUSY,
        RESP = STATE_RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTRUCTION = 1'b0,
        GRANT_DATA        = 1'b1
    } grant_t;

    localparam logic [31:0] ABORT_RDATA = 32'h0;

endpackage

// File: rtl/round_robin_picker_2.sv
// Two-way round-robin winner select: a lone requester wins outright, a tie goes
// to whichever requester did not win the previous grant.
module round_robin_picker_2
    import memory_arbiter_pkg::*;
(
    input  logic   instruction_req,
    input  logic   data_req,
    input  grant_t last_grant,
    output logic   any_req,
    output grant_t winner,
    output logic   tie
);

    // Pick the winner from the pending requests and the previous grant
    always_comb begin
        any_req = instruction_req | data_req;
        tie     = instruction_req & data_req;
        winner  = GRANT_INSTRUCTION;
        if (tie) begin
            winner = (last_grant == GRANT_DATA) ? GRANT_INSTRUCTION : GRANT_DATA;
        end else if (data_req) begin
            winner = GRANT_DATA;
        end
    end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports.
// IDLE picks a requester, BUSY holds the access on the memory bus until
// mem_ready (or the watchdog fires), RESP pulses the winner's ack for one cycle.
module unified_memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   imem_req,
    input  logic [31:2]            imem_address,
    output logic                   imem_ack,
    output logic [31:0]            imem_rdata,
    input  logic                   dmem_req,
    input  logic [31:2]            dmem_address,
    input  logic                   dmem_write_enable,
    input  logic [31:0]            dmem_write_data,
    output logic                   dmem_ack,
    output logic [31:0]            dmem_rdata,
    output logic                   mem_req,
    output logic [31:2]            mem_address,
    output logic                   mem_write_enable,
    output logic [31:0]            mem_write_data,
    input  logic                   mem_ready,
    input  logic [31:0]            mem_rdata,
    output logic [COUNT_WIDTH-1:0] conflict_count,
    output logic                   timeout_error
);

    // wait_count only has to reach TIMEOUT_CYCLES-1
    localparam int WAIT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_WIDTH-1:0]  WAIT_LIMIT = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    arb_state_t            state;
    arb_state_t            next_state;
    grant_t                last_grant;
    grant_t                winner;
    logic                  any_req;
    logic                  tie;
    logic                  take_grant;
    logic                  finish_ok;
    logic                  finish_abort;
    logic [WAIT_WIDTH-1:0] wait_count;
    logic [31:2]           latched_address;
    logic                  latched_we;
    logic [31:0]           latched_wdata;

    round_robin_picker_2 picker (
        .instruction_req (imem_req),
        .data_req        (dmem_req),
        .last_grant      (last_grant),
        .any_req         (any_req),
        .winner          (winner),
        .tie             (tie)
    );

    // All outputs decode registered state only; async reset drops mem_req at once
    assign mem_req          = (state == BUSY);
    assign mem_write_enable = mem_req & latched_we;
    assign mem_address      = latched_address;
    assign mem_write_data   = latched_wdata;
    assign imem_ack         = (state == RESP) && (last_grant == GRANT_INSTRUCTION);
    assign dmem_ack         = (state == RESP) && (last_grant == GRANT_DATA);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the one-cycle grant/completion/abort strobes
    always_comb begin
        next_state   = state;
        take_grant   = 1'b0;
        finish_ok    = 1'b0;
        finish_abort = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = BUSY;
                    take_grant = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    next_state = RESP;
                    finish_ok  = 1'b1;
                end else if (wait_count == WAIT_LIMIT) begin
                    next_state   = RESP;
                    finish_abort = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant bookkeeping, watchdog, contention counter and read-data capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant     <= GRANT_DATA;
            wait_count     <= '0;
            conflict_count <= '0;
            timeout_error  <= 1'b0;
            imem_rdata     <= '0;
            dmem_rdata     <= '0;
        end else begin
            if (take_grant) begin
                last_grant <= winner;
                if (tie && (conflict_count != COUNT_MAX)) begin
                    conflict_count <= conflict_count + 1'b1;
                end
            end
            if ((state == BUSY) && !mem_ready && !finish_abort) begin
                wait_count <= wait_count + 1'b1;
            end
            if (state == RESP) begin
                wait_count <= '0;
            end
            if ((finish_ok || finish_abort) && !latched_we) begin
                if (last_grant == GRANT_INSTRUCTION) begin
                    imem_rdata <= finish_ok ? mem_rdata : ABORT_RDATA;
                end else begin
                    dmem_rdata <= finish_ok ? mem_rdata : ABORT_RDATA;
                end
            end
            if (finish_abort) begin
                timeout_error <= 1'b1;
            end
        end
    end

    // Access latches: captured once at grant, stable for the whole BUSY period
    always_ff @(posedge clock) begin
        if (take_grant) begin
            if (winner == GRANT_DATA) begin
                latched_address <= dmem_address;
                latched_we      <= dmem_write_enable;
                latched_wdata   <= dmem_write_data;
            end else begin
                latched_address <= imem_address;
                latched_we      <= 1'b0;
                latched_wdata   <= '0;
            end
        end
    end

endmodule
